// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator pipeline.
//   - IMM_* : immSrc encodings selecting the immediate format
//   - XLEN_DEFAULT : default immediate output width
//   - imm_entry_t : one buffered result (immediate, error flag, tag)
// Entry fields are sized for the widest supported configuration
// (XLEN 64, TAG_W up to 64); users take the low bits they need.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int MAX_XLEN     = 64;
  localparam int MAX_TAG_W    = 64;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0]  imm;
    logic                 err;
    logic [MAX_TAG_W-1:0] tag;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder.
// Ports:
//   instr  [31:0]     raw instruction (immediate fields live in instr[31:7])
//   immSrc [2:0]      format select (IMM_I..IMM_Z, 110/111 illegal)
//   immExt [XLEN-1:0] extended immediate (0 for illegal formats)
//   immErr            high when immSrc is illegal
// XLEN must be 32 or 64.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immSrc,
  output logic [XLEN-1:0] immExt,
  output logic            immErr
);

  // Every format is first assembled as a 32-bit value; all formats except Z
  // carry their sign in bit 31, so one sign-extending cast covers XLEN 64.
  logic [31:0] imm32;
  logic        sext;

  always_comb begin
    imm32  = '0;
    sext   = 1'b1;
    immErr = 1'b0;
    case (immSrc)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_Z: begin
        // CSR zimm is an unsigned register-index field
        imm32 = {27'b0, instr[19:15]};
        sext  = 1'b0;
      end
      default: begin
        imm32  = '0;
        immErr = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (sext) begin
      immExt = XLEN'($signed(imm32));
    end else begin
      immExt = XLEN'(imm32);
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry skid buffer on the output.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 discard all buffered entries next cycle
//   inValid/inReady       upstream handshake; instr, immSrc, inTag accepted together
//   outValid/outReady     downstream handshake on the head entry
//   immExt, outTag, immErr  contents of the head entry
// TAG_W may be at most 64.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [31:0]      instr,
  input  logic [2:0]       immSrc,
  input  logic [TAG_W-1:0] inTag,
  output logic             outValid,
  input  logic             outReady,
  output logic [XLEN-1:0]  immExt,
  output logic [TAG_W-1:0] outTag,
  output logic             immErr
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr  (instr),
    .immSrc (immSrc),
    .immExt (dec_imm),
    .immErr (dec_err)
  );

  imm_entry_t in_entry;

  always_comb begin
    in_entry     = '0;
    in_entry.imm = MAX_XLEN'(dec_imm);
    in_entry.err = dec_err;
    in_entry.tag = MAX_TAG_W'(inTag);
  end

  logic [1:0] count_reg;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  imm_entry_t mem_reg [2];

  logic push;
  logic pop;

  // inReady depends only on held occupancy plus the flush/reset inputs,
  // never on outReady, so there is no combinational path across the buffer.
  assign inReady  = rst_n && !flush && (count_reg != 2'd2);
  assign outValid = (count_reg != 2'd0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else if (flush) begin
      // Pointers are realigned too; stale storage is simply never read.
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is cleared on reset so the head outputs read as zero afterwards;
  // push already excludes flush cycles through inReady.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= in_entry;
      end
    end
  end

  imm_entry_t head;

  assign head   = mem_reg[rd_ptr_reg];
  assign immExt = head.imm[XLEN-1:0];
  assign outTag = head.tag[TAG_W-1:0];
  assign immErr = head.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        inValid;
  logic        inReady, inReady64;
  logic [31:0] instr;
  logic [2:0]  immSrc;
  logic [31:0] inTag;
  logic        outValid, outValid64;
  logic        outReady;
  logic [31:0] immExt;
  logic [63:0] immExt64;
  logic [31:0] outTag, outTag64;
  logic        immErr, immErr64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .instr(instr), .immSrc(immSrc), .inTag(inTag),
    .outValid(outValid), .outReady(outReady),
    .immExt(immExt), .outTag(outTag), .immErr(immErr)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inValid(inValid), .inReady(inReady64),
    .instr(instr), .immSrc(immSrc), .inTag(inTag),
    .outValid(outValid64), .outReady(outReady),
    .immExt(immExt64), .outTag(outTag64), .immErr(immErr64)
  );

  typedef struct {
    logic [63:0] imm64;
    logic        err;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the format definitions, 64-bit wide.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
    logic [63:0] r;
    case (s)
      3'd0:    r = {{52{i[31]}}, i[31:20]};
      3'd1:    r = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2:    r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    r = {{32{i[31]}}, i[31:12], 12'b0};
      3'd5:    r = {59'b0, i[19:15]};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // One clock: sample at negedge, compare head against scoreboard, update model.
  task automatic cycle(output bit acc);
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = rst_n && !flush && (q.size() < 2);
    chk("in_ready", {63'd0, inReady}, {63'd0, exp_rdy});
    chk("in_ready64", {63'd0, inReady64}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, outValid}, {63'd0, q.size() != 0});
    chk("out_valid64", {63'd0, outValid64}, {63'd0, q.size() != 0});
    if (outValid && q.size() != 0) begin
      chk("head_imm32", {32'd0, immExt}, {32'd0, q[0].imm64[31:0]});
      chk("head_imm64", immExt64, q[0].imm64);
      chk("head_err", {63'd0, immErr}, {63'd0, q[0].err});
      chk("head_tag", {32'd0, outTag}, {32'd0, q[0].tag});
      if (outReady) $display("pop  tag=%0d imm=%h err=%0d", outTag, immExt64, immErr);
    end
    acc = inValid && inReady && rst_n && !flush;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (outValid && outReady && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(cur_exp);
        $display("push tag=%0d instr=%h src=%0d", inTag, instr, immSrc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t,
                        input logic [63:0] e, input logic er);
    instr   = i;
    immSrc  = s;
    inTag   = t;
    inValid = 1'b1;
    cur_exp = '{imm64: e, err: er, tag: t};
  endtask

  task automatic wait_accept(input bool_force_ready);
    bit acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      if (bool_force_ready && n >= 2) outReady = 1'b1;
      cycle(acc);
    end
    if (!acc) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted tag=%0d", inTag);
    end
    inValid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t,
                       input logic [63:0] e, input logic er);
    set_in(i, s, t, e, er);
    wait_accept(1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    inValid = 1'b0;
    repeat (n) cycle(acc);
  endtask

  initial begin
    bit acc;
    logic [31:0] ri;
    logic [2:0]  rs;

    rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    instr = '0; immSrc = '0; inTag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, outValid}, 64'd0);
    chk("rst_in_ready", {63'd0, inReady}, 64'd0);
    chk("rst_imm", {32'd0, immExt}, 64'd0);
    chk("rst_imm64", immExt64, 64'd0);
    chk("rst_tag", {32'd0, outTag}, 64'd0);
    chk("rst_err", {63'd0, immErr}, 64'd0);
    rst_n = 1'b1;

    // Directed decode cases with the downstream always ready
    outReady = 1'b1;
    offer(32'hFFF00093, 3'b000, 32'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    offer(32'hFE000EE3, 3'b010, 32'd11, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    offer(32'h12345037, 3'b100, 32'd12, 64'h0000_0000_1234_5000, 1'b0);
    offer(32'h80000037, 3'b100, 32'd13, 64'hFFFF_FFFF_8000_0000, 1'b0);
    offer(32'h000F8073, 3'b101, 32'd14, 64'h0000_0000_0000_001F, 1'b0);
    offer(32'hFFFFFFFF, 3'b110, 32'd15, 64'd0, 1'b1);
    offer(32'hFFFFFFFF, 3'b111, 32'd16, 64'd0, 1'b1);
    offer(32'hFE1FA023, 3'b001, 32'd17, 64'hFFFF_FFFF_FFFF_FFE0, 1'b0);
    offer(32'h8000006F, 3'b011, 32'd18, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    idle(2);

    // Back-pressure: tags 1,2,3 with the consumer stalled
    outReady = 1'b0;
    set_in(32'h00100093, 3'b000, 32'd1, 64'd1, 1'b0);
    wait_accept(1'b0);
    set_in(32'h00200093, 3'b000, 32'd2, 64'd2, 1'b0);
    wait_accept(1'b0);
    set_in(32'h00300093, 3'b000, 32'd3, 64'd3, 1'b0);
    repeat (3) cycle(acc);
    outReady = 1'b1;
    wait_accept(1'b0);
    idle(3);

    // Flush while full with a new instruction offered
    outReady = 1'b0;
    offer(32'h00500093, 3'b000, 32'd21, 64'd5, 1'b0);
    offer(32'h00600093, 3'b000, 32'd22, 64'd6, 1'b0);
    set_in(32'h00700093, 3'b000, 32'd23, 64'd7, 1'b0);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    idle(3);

    // Reset while full and flushing
    outReady = 1'b0;
    offer(32'h00800093, 3'b000, 32'd31, 64'd8, 1'b0);
    offer(32'h00900093, 3'b000, 32'd32, 64'd9, 1'b0);
    flush = 1'b1;
    rst_n = 1'b0;
    cycle(acc);
    rst_n = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
    chk("mrst_out_valid", {63'd0, outValid}, 64'd0);
    chk("mrst_imm", {32'd0, immExt}, 64'd0);
    chk("mrst_imm64", immExt64, 64'd0);
    chk("mrst_tag", {32'd0, outTag}, 64'd0);
    chk("mrst_err", {63'd0, immErr}, 64'd0);
    outReady = 1'b1;
    idle(3);

    // Random formats with random back-pressure
    for (int k = 0; k < 12; k++) begin
      ri = $urandom;
      rs = 3'($urandom_range(0, 7));
      outReady = ($urandom_range(0, 3) != 0);
      set_in(ri, rs, 32'(100 + k), ref_imm(ri, rs), rs >= 3'd6);
      wait_accept(1'b1);
    end
    outReady = 1'b1;
    idle(4);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (PC/rd) carried with each immediate.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port inValid  input  1  upstream offers an instruction.
REQ-007 SHALL have port inReady  output  1  block can accept this cycle.
REQ-008 SHALL have port instr  input  32  raw instruction; immediate fields taken from instr[31:7].
REQ-009 SHALL have port immSrc  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110/111 illegal.
REQ-010 SHALL have port inTag  input  TAG_W  sideband travelling with the instruction.
REQ-011 SHALL have port outValid  output  1  head entry valid.
REQ-012 SHALL have port outReady  input  1  downstream consumes head entry.
REQ-013 SHALL have port immExt  output  XLEN  extended immediate of head entry.
REQ-014 SHALL have port outTag  output  TAG_W  tag of head entry.
REQ-015 SHALL have port immErr  output  1  head entry had an illegal immSrc.

Function
REQ-016 SHALL decode: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); U = sext({instr[31:12],12'b0}); Z = zext(instr[19:15]).
REQ-017 SHALL sign-extend from instr[31] to XLEN bits; Z-format SHALL zero-extend.
REQ-018 SHALL, for immSrc 110/111, store immExt = 0 and immErr = 1; immErr SHALL be 0 for all legal formats.
REQ-019 SHALL hold results in a 2-entry FIFO skid buffer (entry = immExt, immErr, outTag) with occupancy count 0..2.
REQ-020 SHALL accept (push) when inValid && inReady; inReady = (count < 2) && !flush, driven from registered state only.
REQ-021 SHALL pop when outValid && outReady; outValid = (count != 0).
REQ-022 SHALL present an accepted instruction at the outputs the cycle after acceptance when the buffer was empty (latency 1).
REQ-023 SHALL deliver entries strictly in acceptance order.
REQ-024 SHALL, on simultaneous push and pop at count 1, keep count 1 with the new entry at head next cycle.
REQ-025 SHALL, at count 2, hold inReady low; no entry is overwritten or dropped.
REQ-026 SHALL, when flush is high, set count to 0 next cycle, ignore any push and pop that cycle, and leave entry storage contents don't-care.
REQ-027 SHALL keep immExt/outTag/immErr stable while outValid && !outReady.

Reset
REQ-028 SHALL, when rst_n is low at a clock edge, set count 0, outValid 0, inReady 0 during that cycle, immExt 0, outTag 0, immErr 0.
REQ-029 SHALL give reset priority over flush, push and pop; mid-operation reset discards all entries.
REQ-030 SHALL assert inReady in the first cycle after rst_n returns high.

Structure
REQ-031 SHALL place immSrc encodings (IMM_I..IMM_Z), the default XLEN and the entry record type in shared package imm_pkg.
REQ-032 SHALL split the combinational decode into sub-module imm_decode (instr, immSrc -> immExt, immErr, parameter XLEN); imm_gen_pipe holds only the FIFO and handshake.

Verification
REQ-033 SHALL cover: XLEN=32, instr 0xFFF00093, immSrc I, outReady=1 -> next cycle outValid 1, immExt 0xFFFFFFFF, immErr 0.
REQ-034 SHALL cover: instr 0xFE000EE3 immSrc B -> immExt 0xFFFFFFFC; instr 0x12345037 immSrc U -> 0x12345000; XLEN=64, 0x80000037 U -> 0xFFFFFFFF80000000.
REQ-035 SHALL cover: outReady=0, offer tags 1,2,3 back-to-back -> inReady low after second accept, tag 3 held; raise outReady -> tags out 1,2,3 in order, no loss.
REQ-036 SHALL cover: count 2, flush=1 with inValid=1 -> next cycle outValid 0, inReady 1, offered instruction not delivered.
REQ-037 SHALL cover: immSrc 3'b110 -> immErr 1, immExt 0; immSrc 101 with instr[19:15]=5'h1F -> immExt 0x0000001F.
REQ-038 SHALL cover: rst_n low for one cycle with count 2 and flush=1 -> all outputs 0, no stale entry emerges afterwards.
